// File: rtl/traffic_light_controller_param.sv
// Round-robin N-approach intersection controller with amber/all-red clearance,
// pedestrian green extension, emergency preemption and night amber flash.
module traffic_light_controller_param #(
    parameter int N_APP      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int AMBER_CYC  = 2,
    parameter int ALLRED_CYC = 1,
    parameter int PED_EXT    = 4,
    parameter int FLASH_CYC  = 3,
    parameter int CNT_W      = 8,
    localparam int AW        = $clog2(N_APP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             night_mode,
    input  logic [N_APP-1:0] ped_req,
    input  logic             emerg_req,
    input  logic [AW-1:0]    emerg_dir,
    output logic [N_APP-1:0] go_l,
    output logic [N_APP-1:0] go_r,
    output logic [N_APP-1:0] go_o,
    output logic [N_APP-1:0] amber,
    output logic [N_APP-1:0] red,
    output logic [N_APP-1:0] ped_walk,
    output logic [AW-1:0]    cur_app,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_AMBER  = 3'd2,
        S_EMERG  = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_XLAST = CNT_W'(GREEN_CYC + PED_EXT - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST  = CNT_W'(AMBER_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);
    localparam logic [AW-1:0]    LAST_APP    = AW'(N_APP - 1);
    localparam logic [N_APP-1:0] ONE_MASK    = {{(N_APP-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [AW-1:0]      r_cur;
    logic [N_APP-1:0]   r_ped;
    logic               r_ped_act;
    logic               r_flash;
    logic               r_restart;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [AW-1:0]      w_cur_nx;
    logic [N_APP-1:0]   w_ped_nx;
    logic               w_ped_act_nx;
    logic               w_flash_nx;
    logic               w_restart_nx;
    logic [AW-1:0]      w_next_app;
    logic [N_APP-1:0]   w_next_mask;
    logic [N_APP-1:0]   w_cur_mask;
    logic [CNT_W-1:0]   w_green_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_ALLRED;
            r_cnt     <= '0;
            r_cur     <= '0;
            r_ped     <= '0;
            r_ped_act <= 1'b0;
            r_flash   <= 1'b0;
            r_restart <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_cur     <= w_cur_nx;
            r_ped     <= w_ped_nx;
            r_ped_act <= w_ped_act_nx;
            r_flash   <= w_flash_nx;
            r_restart <= w_restart_nx;
        end
    end

    // r_restart makes the next green start at approach 0 (after reset or night flash)
    always_comb begin
        w_next_app   = '0;
        if (!r_restart && (r_cur != LAST_APP)) begin
            w_next_app = r_cur + 1'b1;
        end
        w_next_mask  = ONE_MASK << w_next_app;
        w_green_last = r_ped_act ? GREEN_XLAST : GREEN_LAST;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 1'b1;
        w_cur_nx     = r_cur;
        w_ped_nx     = r_ped | ped_req;
        w_ped_act_nx = r_ped_act;
        w_flash_nx   = r_flash;
        w_restart_nx = r_restart;

        case (r_state)
            S_ALLRED: begin
                if (r_cnt == ALLRED_LAST) begin
                    w_cnt_nx = '0;
                    if (emerg_req) begin
                        w_state_nx   = S_EMERG;
                        w_cur_nx     = emerg_dir;
                        w_restart_nx = 1'b0;
                    end else if (night_mode) begin
                        w_state_nx = S_FLASH;
                        w_flash_nx = 1'b1;
                    end else begin
                        // a request on the entry edge itself survives for the next green
                        w_state_nx   = S_GREEN;
                        w_cur_nx     = w_next_app;
                        w_ped_act_nx = |(r_ped & w_next_mask);
                        w_ped_nx     = (r_ped & ~w_next_mask) | ped_req;
                        w_restart_nx = 1'b0;
                    end
                end
            end
            S_GREEN: begin
                if (emerg_req && (emerg_dir == r_cur)) begin
                    w_state_nx = S_EMERG;
                    w_cnt_nx   = '0;
                end else if (emerg_req || (r_cnt == w_green_last)) begin
                    w_state_nx = S_AMBER;
                    w_cnt_nx   = '0;
                end
            end
            S_AMBER: begin
                if (r_cnt == AMBER_LAST) begin
                    w_state_nx = S_ALLRED;
                    w_cnt_nx   = '0;
                end
            end
            S_EMERG: begin
                w_cnt_nx = '0;
                if (!emerg_req) begin
                    w_state_nx = S_AMBER;
                end
            end
            S_FLASH: begin
                if (emerg_req || !night_mode) begin
                    w_state_nx   = S_ALLRED;
                    w_cnt_nx     = '0;
                    w_restart_nx = 1'b1;
                end else if (r_cnt == FLASH_LAST) begin
                    w_cnt_nx   = '0;
                    w_flash_nx = ~r_flash;
                end
            end
            default: begin
                w_state_nx = S_ALLRED;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        w_cur_mask = ONE_MASK << r_cur;
        go_l       = '0;
        go_r       = '0;
        go_o       = '0;
        amber      = '0;
        ped_walk   = '0;
        case (r_state)
            S_GREEN, S_EMERG: begin
                go_l = w_cur_mask;
                go_r = w_cur_mask;
                go_o = w_cur_mask;
                if ((r_state == S_GREEN) && r_ped_act) begin
                    ped_walk = w_cur_mask;
                end
            end
            S_AMBER: amber = w_cur_mask;
            S_FLASH: amber = {N_APP{r_flash}};
            default: ;
        endcase
        red     = ~(go_o | amber);
        cur_app = r_cur;
        state_o = r_state;
    end

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Self-checking bench: directed scenarios with hand-derived schedules plus
// randomized traffic compared every cycle against a phase-level reference model.
module tb_traffic_light_controller_param;

    localparam int N          = 4;
    localparam int AW         = 2;
    localparam int GREEN_CYC  = 8;
    localparam int AMBER_CYC  = 2;
    localparam int ALLRED_CYC = 1;
    localparam int PED_EXT    = 4;
    localparam int FLASH_CYC  = 3;
    localparam int PERIOD     = GREEN_CYC + AMBER_CYC + ALLRED_CYC;
    localparam int BW         = 6 * N + AW + 3;

    localparam int P_ALLRED = 0;
    localparam int P_GREEN  = 1;
    localparam int P_AMBER  = 2;
    localparam int P_EMERG  = 3;
    localparam int P_FLASH  = 4;

    logic          clk;
    logic          rst;
    logic          night_mode;
    logic [N-1:0]  ped_req;
    logic          emerg_req;
    logic [AW-1:0] emerg_dir;
    logic [N-1:0]  go_l, go_r, go_o, amber, red, ped_walk;
    logic [AW-1:0] cur_app;
    logic [2:0]    state_o;
    logic [BW-1:0] dut_bus;

    int errors = 0;
    int checks = 0;

    int           m_phase, m_left, m_app, m_fleft;
    bit           m_ext, m_flash, m_home;
    bit [N-1:0]   m_ped;

    traffic_light_controller_param #(
        .N_APP(N), .GREEN_CYC(GREEN_CYC), .AMBER_CYC(AMBER_CYC), .ALLRED_CYC(ALLRED_CYC),
        .PED_EXT(PED_EXT), .FLASH_CYC(FLASH_CYC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .night_mode(night_mode), .ped_req(ped_req),
        .emerg_req(emerg_req), .emerg_dir(emerg_dir),
        .go_l(go_l), .go_r(go_r), .go_o(go_o), .amber(amber), .red(red),
        .ped_walk(ped_walk), .cur_app(cur_app), .state_o(state_o)
    );

    assign dut_bus = {go_l, go_r, go_o, amber, red, ped_walk, cur_app, state_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phases with remaining-cycle countdowns, updated from the same inputs the DUT samples
    always @(posedge clk) begin
        if (!rst) begin
            m_phase = P_ALLRED; m_left = ALLRED_CYC; m_app = 0; m_ped = '0;
            m_ext = 0; m_flash = 0; m_home = 1; m_fleft = 0;
        end else begin
            case (m_phase)
                P_GREEN: begin
                    if (emerg_req && int'(emerg_dir) == m_app) m_phase = P_EMERG;
                    else if (emerg_req || m_left == 1) begin m_phase = P_AMBER; m_left = AMBER_CYC; end
                    else m_left--;
                end
                P_AMBER: begin
                    if (m_left == 1) begin m_phase = P_ALLRED; m_left = ALLRED_CYC; end
                    else m_left--;
                end
                P_ALLRED: begin
                    if (m_left > 1) m_left--;
                    else if (emerg_req) begin m_phase = P_EMERG; m_app = int'(emerg_dir); m_home = 0; end
                    else if (night_mode) begin m_phase = P_FLASH; m_flash = 1; m_fleft = FLASH_CYC; end
                    else begin
                        m_app = m_home ? 0 : (m_app + 1) % N;
                        m_home = 0;
                        m_ext = m_ped[m_app];
                        m_ped[m_app] = 1'b0;
                        m_left = GREEN_CYC + (m_ext ? PED_EXT : 0);
                        m_phase = P_GREEN;
                    end
                end
                P_EMERG: begin
                    if (!emerg_req) begin m_phase = P_AMBER; m_left = AMBER_CYC; end
                end
                P_FLASH: begin
                    if (emerg_req || !night_mode) begin m_phase = P_ALLRED; m_left = ALLRED_CYC; m_home = 1; end
                    else if (m_fleft == 1) begin m_flash = ~m_flash; m_fleft = FLASH_CYC; end
                    else m_fleft--;
                end
                default: m_phase = P_ALLRED;
            endcase
            m_ped = m_ped | ped_req;
        end
    end

    function automatic logic [BW-1:0] exp_bus();
        logic [N-1:0] oh, g, a, w;
        oh = 4'b0001 << m_app;
        g  = (m_phase == P_GREEN || m_phase == P_EMERG) ? oh : '0;
        a  = (m_phase == P_AMBER) ? oh : (m_phase == P_FLASH) ? {N{m_flash}} : '0;
        w  = (m_phase == P_GREEN && m_ext) ? oh : '0;
        return {g, g, g, a, ~(g | a), w, AW'(m_app), 3'(m_phase)};
    endfunction

    task automatic do_reset();
        rst = 1'b0; night_mode = 1'b0; ped_req = '0; emerg_req = 1'b0; emerg_dir = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ((go_l | go_r | go_o) !== '0) begin errors++; $display("[TB] FAIL reset_go got=%b/%b/%b need 0", go_l, go_r, go_o); end
        checks++;
        if (amber !== '0) begin errors++; $display("[TB] FAIL reset_amber got=%b need 0000", amber); end
        checks++;
        if (red !== 4'b1111) begin errors++; $display("[TB] FAIL reset_red got=%b need 1111", red); end
        checks++;
        if (ped_walk !== '0) begin errors++; $display("[TB] FAIL reset_walk got=%b need 0000", ped_walk); end
        checks++;
        if (cur_app !== 2'd0) begin errors++; $display("[TB] FAIL reset_cur got=%0d need 0", cur_app); end
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d need 0", state_o); end
    endtask

    task automatic test_rotation();
        int t, app, ph, es;
        logic [N-1:0] oh, eg, ea;
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 2 + 2 * N * PERIOD; c++) begin
            @(negedge clk);
            t = c - 2; app = (t / PERIOD) % N; ph = t % PERIOD;
            es = (ph < GREEN_CYC) ? 1 : (ph < GREEN_CYC + AMBER_CYC) ? 2 : 0;
            oh = 4'b0001 << app;
            eg = (es == 1) ? oh : '0;
            ea = (es == 2) ? oh : '0;
            checks++;
            if ({state_o, cur_app, go_o, amber} !== {3'(es), AW'(app), eg, ea}) begin
                errors++;
                $display("[TB] FAIL rotation c=%0d got st=%0d app=%0d go=%b amb=%b need st=%0d app=%0d go=%b amb=%b",
                         c, state_o, cur_app, go_o, amber, es, app, eg, ea);
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL rotation_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_rotation c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
        end
    endtask

    task automatic test_ped();
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 82; c++) begin
            @(negedge clk);
            if (c >= 24 && c <= 35) begin
                checks++;
                if ({state_o, cur_app, ped_walk} !== {3'd1, 2'd2, 4'b0100}) begin
                    errors++; $display("[TB] FAIL ped_ext c=%0d got st=%0d app=%0d walk=%b need 1/2/0100", c, state_o, cur_app, ped_walk);
                end
            end
            if (c == 36 || c == 80) begin
                checks++;
                if ({state_o, cur_app} !== {3'd2, 2'd2}) begin
                    errors++; $display("[TB] FAIL ped_end c=%0d got st=%0d app=%0d need 2/2", c, state_o, cur_app);
                end
            end
            if (c >= 72 && c <= 79) begin
                checks++;
                if ({state_o, cur_app, ped_walk} !== {3'd1, 2'd2, 4'b0000}) begin
                    errors++; $display("[TB] FAIL ped_consumed c=%0d got st=%0d app=%0d walk=%b need 1/2/0000", c, state_o, cur_app, ped_walk);
                end
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL ped_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_ped c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            ped_req = (c == 4) ? 4'b0100 : 4'b0000;
        end
    endtask

    task automatic test_emerg_other();
        logic [5:0] exp;
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            exp = 6'h3f;
            if (c >= 13 && c <= 15) exp = {3'd1, 1'b0, 2'd1};
            if (c == 16 || c == 17) exp = {3'd2, 1'b0, 2'd1};
            if (c == 18)            exp = {3'd0, 1'b0, 2'd1};
            if (c >= 19 && c <= 38) exp = {3'd3, 1'b0, 2'd3};
            if (c == 39 || c == 40) exp = {3'd2, 1'b0, 2'd3};
            if (c == 41)            exp = {3'd0, 1'b0, 2'd3};
            if (c >= 42 && c <= 49) exp = {3'd1, 1'b0, 2'd0};
            if (exp != 6'h3f) begin
                checks++;
                if ({state_o, 1'b0, cur_app} !== exp) begin
                    errors++; $display("[TB] FAIL emerg_other c=%0d got st=%0d app=%0d need st=%0d app=%0d", c, state_o, cur_app, exp[5:3], exp[1:0]);
                end
            end
            if (c >= 19 && c <= 38) begin
                checks++;
                if ({go_l, go_r, go_o, amber} !== {4'b1000, 4'b1000, 4'b1000, 4'b0000}) begin
                    errors++; $display("[TB] FAIL emerg_lamps c=%0d got %b/%b/%b/%b need S greens only", c, go_l, go_r, go_o, amber);
                end
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL emerg_other_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_emerg c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            if (c == 15) begin emerg_req = 1'b1; emerg_dir = 2'd3; end
            if (c == 38) emerg_req = 1'b0;
        end
    endtask

    task automatic test_emerg_same();
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 24; c++) begin
            @(negedge clk);
            if (c >= 6 && c <= 10) begin
                checks++;
                if ({state_o, cur_app, go_l, go_r, go_o, amber} !== {3'd3, 2'd0, 4'b0001, 4'b0001, 4'b0001, 4'b0000}) begin
                    errors++; $display("[TB] FAIL emerg_same c=%0d got st=%0d app=%0d go=%b amb=%b need 3/0/0001/0000", c, state_o, cur_app, go_o, amber);
                end
            end
            if (c == 11 || c == 12 || c == 13 || (c >= 14 && c <= 21)) begin
                checks++;
                if ({state_o, cur_app} !== ((c <= 12) ? {3'd2, 2'd0} : (c == 13) ? {3'd0, 2'd0} : {3'd1, 2'd1})) begin
                    errors++; $display("[TB] FAIL emerg_same_exit c=%0d got st=%0d app=%0d", c, state_o, cur_app);
                end
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL emerg_same_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_same c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            if (c == 5) begin emerg_req = 1'b1; emerg_dir = 2'd0; end
            if (c == 10) emerg_req = 1'b0;
        end
    endtask

    task automatic test_night();
        logic [N-1:0] ea;
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 13 && c <= 21) begin
                ea = (((c - 13) / FLASH_CYC) % 2 == 0) ? 4'b1111 : 4'b0000;
                checks++;
                if ({state_o, amber, go_l | go_r | go_o} !== {3'd4, ea, 4'b0000}) begin
                    errors++; $display("[TB] FAIL night_flash c=%0d got st=%0d amb=%b need st=4 amb=%b", c, state_o, amber, ea);
                end
            end
            if (c == 12 || c == 22) begin
                checks++;
                if ({state_o, amber} !== {3'd0, 4'b0000}) begin
                    errors++; $display("[TB] FAIL night_allred c=%0d got st=%0d amb=%b need 0/0000", c, state_o, amber);
                end
            end
            if (c >= 23 && c <= 34) begin
                checks++;
                if ({state_o, cur_app, ped_walk} !== {3'd1, 2'd0, 4'b0001}) begin
                    errors++; $display("[TB] FAIL night_ped c=%0d got st=%0d app=%0d walk=%b need 1/0/0001", c, state_o, cur_app, ped_walk);
                end
            end
            if (c == 35) begin
                checks++;
                if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL night_ped_end c=%0d got st=%0d need 2", c, state_o); end
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL night_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_night c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            if (c == 3) night_mode = 1'b1;
            if (c == 21) night_mode = 1'b0;
            ped_req = (c == 15) ? 4'b0001 : 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            if (c == 11) begin
                checks++;
                if (dut_bus !== {12'h000, 4'b0000, 4'b1111, 4'b0000, 2'd0, 3'd0}) begin
                    errors++; $display("[TB] FAIL reset_mid c=%0d got=%h need all red idle", c, dut_bus);
                end
            end
            if ((c >= 12 && c <= 19) || (c >= 23 && c <= 30)) begin
                checks++;
                if ({state_o, cur_app, ped_walk} !== {3'd1, (c <= 19) ? 2'd0 : 2'd1, 4'b0000}) begin
                    errors++; $display("[TB] FAIL reset_mid_green c=%0d got st=%0d app=%0d walk=%b", c, state_o, cur_app, ped_walk);
                end
            end
            if (c == 31) begin
                checks++;
                if ({state_o, cur_app} !== {3'd2, 2'd1}) begin
                    errors++; $display("[TB] FAIL reset_mid_latch c=%0d got st=%0d app=%0d need 2/1", c, state_o, cur_app);
                end
            end
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL reset_mid_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_reset c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            ped_req = (c == 3) ? 4'b0010 : 4'b0000;
            rst = (c == 10) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_random();
        do_reset();
        rst = 1'b1;
        for (int c = 2; c <= 1500; c++) begin
            @(negedge clk);
            checks++;
            if (dut_bus !== exp_bus()) begin errors++; $display("[TB] FAIL random_model c=%0d got=%h need=%h", c, dut_bus, exp_bus()); end
            checks++;
            if (state_o != 3'd4 && $countones(go_l | go_r | go_o | amber) > 1) begin
                errors++; $display("[TB] FAIL onehot_random c=%0d got go=%b amb=%b need at most one lit", c, go_o, amber);
            end
            ped_req   = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            emerg_dir = AW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 39) == 0) emerg_req = ~emerg_req;
            if ($urandom_range(0, 59) == 0) night_mode = ~night_mode;
            rst = ($urandom_range(0, 299) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_ped();
        test_emerg_other();
        test_emerg_same();
        test_night();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
